// File: rtl/tx_sched_pkg.sv
// Shared types and parameter defaults for the transmit packet scheduler.
package tx_sched_pkg;

  localparam int VID_BURST_DEF  = 10;
  localparam int AUX_LEN_DEF    = 32;
  localparam int AUX_STREAK_DEF = 4;
  localparam int IFG_DEF        = 12;
  localparam int ACK_TMO_DEF    = 255;

  // aux_pend is a 5-bit saturating count of completed ADE periods
  localparam int PEND_MAX = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_BURST,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_VID  = 2'b01,
    TYPE_AUX  = 2'b10
  } pkt_type_e;

endpackage

// File: rtl/tx_pkt_sched_if.sv
// Scheduler-side bundle: FIFO read controls, transmitter handshake, status.
interface tx_pkt_sched_if;
  logic        vid_rdy;
  logic        vid_rd_en;
  logic        aux_req;
  logic [3:0]  aux_num;
  logic        aux_empty;
  logic        aux_rd_en;
  logic        pkt_start;
  logic [1:0]  pkt_type;
  logic [5:0]  pkt_len;
  logic        pkt_ack;
  logic        pkt_done;
  logic        busy;
  logic        err_tmo;
  logic [15:0] vid_pkts;
  logic [15:0] aux_pkts;

  // scheduler side
  modport master (
    input  vid_rdy, aux_req, aux_num, aux_empty, pkt_ack, pkt_done,
    output vid_rd_en, aux_rd_en, pkt_start, pkt_type, pkt_len,
           busy, err_tmo, vid_pkts, aux_pkts
  );

  // FIFOs / transmitter side
  modport slave (
    output vid_rdy, aux_req, aux_num, aux_empty, pkt_ack, pkt_done,
    input  vid_rd_en, aux_rd_en, pkt_start, pkt_type, pkt_len,
           busy, err_tmo, vid_pkts, aux_pkts
  );
endinterface

// File: rtl/tx_sched_arb.sv
// Video/aux arbiter: aux has priority, but after AUX_STREAK back-to-back aux
// grants a ready video source gets one turn so it is never starved.
module tx_sched_arb
  import tx_sched_pkg::*;
#(
  parameter int AUX_STREAK = AUX_STREAK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       vid_rdy,
  input  logic       aux_empty,
  input  logic [4:0] aux_pend,
  output logic       gnt_vid,
  output logic       gnt_aux
);

  localparam int SW = $clog2(AUX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(AUX_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          aux_el, vid_el, capped;

  // Eligibility, priority and streak bookkeeping.
  always_comb begin
    aux_el   = (aux_pend != 5'd0) && !aux_empty;
    vid_el   = vid_rdy;
    capped   = (streak_q == STREAK_MAX);
    gnt_aux  = en && aux_el && !(capped && vid_el);
    gnt_vid  = en && vid_el && !gnt_aux;
    streak_d = streak_q;
    if (gnt_vid)
      streak_d = '0;
    else if (gnt_aux && !capped)
      streak_d = streak_q + SW'(1);
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/tx_pkt_sched.sv
// Transmit packet scheduler: picks video or aux, runs the start/ack/burst/done
// handshake with the GMII framer and enforces the inter-frame gap.
module tx_pkt_sched
  import tx_sched_pkg::*;
#(
  parameter int VID_BURST  = VID_BURST_DEF,
  parameter int AUX_LEN    = AUX_LEN_DEF,
  parameter int AUX_STREAK = AUX_STREAK_DEF,
  parameter int IFG        = IFG_DEF,
  parameter int ACK_TMO    = ACK_TMO_DEF
) (
  input  logic           tx_clk,
  input  logic           rstbtn_n,
  tx_pkt_sched_if.master bus
);

  localparam int TW = $clog2(ACK_TMO + 1);
  localparam int GW = $clog2(IFG + 1);
  localparam logic [5:0] VID_LEN = 6'(VID_BURST);
  localparam logic [5:0] AUX_LN  = 6'(AUX_LEN);

  state_e        state_q, state_d;
  pkt_type_e     type_q, type_d;
  logic [5:0]    len_q, len_d;
  logic [5:0]    burst_q, burst_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    aux_pend_q, aux_pend_d;
  logic [15:0]   vid_pkts_q, vid_pkts_d;
  logic [15:0]   aux_pkts_q, aux_pkts_d;

  logic       gnt_vid, gnt_aux;
  logic       pend_dec;
  logic [5:0] pend_sum;
  logic       pkt_start, err_tmo, vid_rd_en, aux_rd_en;

  tx_sched_arb #(.AUX_STREAK(AUX_STREAK)) u_arb (
    .clk       (tx_clk),
    .rst_n     (rstbtn_n),
    .en        (state_q == S_IDLE),
    .vid_rdy   (bus.vid_rdy),
    .aux_empty (bus.aux_empty),
    .aux_pend  (aux_pend_q),
    .gnt_vid   (gnt_vid),
    .gnt_aux   (gnt_aux)
  );

  // Next-state, handshake strobes and per-packet bookkeeping.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    len_d      = len_q;
    burst_d    = burst_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    vid_pkts_d = vid_pkts_q;
    aux_pkts_d = aux_pkts_q;
    pend_dec   = 1'b0;
    pkt_start  = 1'b0;
    err_tmo    = 1'b0;
    vid_rd_en  = 1'b0;
    aux_rd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // type/len are set on the grant edge so they are valid with pkt_start
        if (gnt_vid) begin
          type_d  = TYPE_VID;
          len_d   = VID_LEN;
          state_d = S_START;
        end else if (gnt_aux) begin
          type_d  = TYPE_AUX;
          len_d   = AUX_LN;
          state_d = S_START;
        end
      end
      S_START: begin
        pkt_start = 1'b1;
        tmo_d     = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.pkt_ack) begin
          burst_d = '0;
          state_d = S_BURST;
        end else if (tmo_q == TW'(ACK_TMO)) begin
          // abandon the packet: nothing read, nothing counted
          err_tmo = 1'b1;
          type_d  = TYPE_NONE;
          len_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_BURST: begin
        // burst length is fixed at grant; aux_empty is not consulted here
        vid_rd_en = (type_q == TYPE_VID);
        aux_rd_en = (type_q == TYPE_AUX);
        if (burst_q == len_q - 6'd1) state_d = S_WAIT_DONE;
        else                         burst_d = burst_q + 6'd1;
      end
      S_WAIT_DONE: begin
        if (bus.pkt_done) begin
          if (type_q == TYPE_VID) begin
            vid_pkts_d = vid_pkts_q + 16'd1;
          end else begin
            aux_pkts_d = aux_pkts_q + 16'd1;
            pend_dec   = (aux_pend_q != 5'd0);
          end
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IFG - 1)) begin
          type_d  = TYPE_NONE;
          len_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending aux periods: net add/decrement, saturating at PEND_MAX.
  always_comb begin
    pend_sum   = {1'b0, aux_pend_q}
               + (bus.aux_req ? {2'b00, bus.aux_num} : 6'd0)
               - {5'd0, pend_dec};
    aux_pend_d = (pend_sum > 6'(PEND_MAX)) ? 5'(PEND_MAX) : pend_sum[4:0];
  end

  // State and counter registers.
  always_ff @(posedge tx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q    <= S_IDLE;
      type_q     <= TYPE_NONE;
      len_q      <= '0;
      burst_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      aux_pend_q <= '0;
      vid_pkts_q <= '0;
      aux_pkts_q <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      aux_pend_q <= aux_pend_d;
      vid_pkts_q <= vid_pkts_d;
      aux_pkts_q <= aux_pkts_d;
    end
  end

  assign bus.vid_rd_en = vid_rd_en;
  assign bus.aux_rd_en = aux_rd_en;
  assign bus.pkt_start = pkt_start;
  assign bus.pkt_type  = type_q;
  assign bus.pkt_len   = len_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err_tmo   = err_tmo;
  assign bus.vid_pkts  = vid_pkts_q;
  assign bus.aux_pkts  = aux_pkts_q;

endmodule

// File: tb/tb_tx_pkt_sched.sv
// Randomized bench for tx_pkt_sched with a packet-level reference model.
module tb_tx_pkt_sched;

  localparam int VB  = 10;   // video entries per packet
  localparam int AL  = 32;   // aux entries per packet
  localparam int AS  = 4;    // aux streak limit
  localparam int GAP = 14;   // done -> next start spacing (IFG + 2)
  localparam int TMO = 256;  // start -> err_tmo (entry + 255)

  logic tx_clk = 1'b0;
  logic rstbtn_n = 1'b0;
  int   cyc = 0;
  int   errs = 0, checks = 0;
  int   both_cnt = 0, vid_rd_cyc = 0, aux_rd_cyc = 0;

  // model state
  int m_pend = 0, m_run = 0, m_vid = 0, m_aux = 0;
  bit have_prev = 0;
  int last_done = 0;
  int ord = 0;

  tx_pkt_sched_if bus ();

  tx_pkt_sched dut (
    .tx_clk   (tx_clk),
    .rstbtn_n (rstbtn_n),
    .bus      (bus)
  );

  always #4 tx_clk = ~tx_clk;
  always @(posedge tx_clk) cyc <= cyc + 1;

  always @(negedge tx_clk) begin
    if (bus.vid_rd_en && bus.aux_rd_en) both_cnt <= both_cnt + 1;
    if (bus.vid_rd_en) vid_rd_cyc <= vid_rd_cyc + 1;
    if (bus.aux_rd_en) aux_rd_cyc <= aux_rd_cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge tx_clk);
  endtask

  function automatic int min31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  // Which source the arbitration rules pick: 2 = aux, 1 = video, 0 = none.
  function automatic int predict();
    bit aux_ok, vid_ok;
    aux_ok = (m_pend > 0) && !bus.aux_empty;
    vid_ok = bus.vid_rdy;
    if (aux_ok && !(m_run >= AS && vid_ok)) return 2;
    if (vid_ok) return 1;
    return 0;
  endfunction

  task automatic grant(input int t);
    if (t == 2) m_run = (m_run < AS) ? m_run + 1 : m_run;
    else if (t == 1) m_run = 0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.pkt_start) begin ok = 1; break; end
    end
  endtask

  task automatic pulse_req(input int num);
    bus.aux_req = 1'b1;
    bus.aux_num = 4'(num);
    tick();
    bus.aux_req = 1'b0;
    m_pend = min31(m_pend + num);
    tick();
    chk("pend_after_req", dut.aux_pend_q, m_pend);
  endtask

  // One full packet: start, ack, burst window, done; optional aux_req
  // injected either mid-WAIT_DONE or coincident with pkt_done.
  task automatic do_pkt(input int ack_dly, input int extra, input bit req,
                        input int num, input bit req_at_done);
    int exp_t, exp_len, done_dly, s, m, first, last, hits, wrong;
    bit ok;
    exp_t   = predict();
    exp_len = (exp_t == 2) ? AL : VB;
    done_dly = exp_len + 3 + extra;
    wait_start(ok);
    chk("start_seen", ok, 1);
    if (!ok) return;
    s = cyc;
    if (have_prev) chk("pkt_spacing", s - last_done, GAP);
    chk("pkt_type", bus.pkt_type, exp_t);
    chk("pkt_len", bus.pkt_len, exp_len);
    ord = ord * 2 + ((bus.pkt_type == 2'b10) ? 1 : 0);
    grant(exp_t);
    repeat (ack_dly) tick();
    bus.pkt_ack = 1'b1;
    m = cyc;
    tick();
    bus.pkt_ack = 1'b0;
    first = -1; last = -1; hits = 0; wrong = 0;
    for (int i = 1; i <= done_dly; i++) begin
      if (bus.vid_rd_en || bus.aux_rd_en) begin
        if ((exp_t == 1 && bus.vid_rd_en && !bus.aux_rd_en) ||
            (exp_t == 2 && bus.aux_rd_en && !bus.vid_rd_en)) begin
          hits++;
          if (first < 0) first = cyc;
          last = cyc;
        end else wrong++;
      end
      if (req && !req_at_done) begin
        if (i == exp_len + 2) begin
          bus.aux_req = 1'b1;
          bus.aux_num = 4'(num);
          m_pend = min31(m_pend + num);
        end else bus.aux_req = 1'b0;
      end
      if (i < done_dly) tick();
    end
    bus.pkt_done = 1'b1;
    last_done = cyc;
    if (req && req_at_done) begin
      bus.aux_req = 1'b1;
      bus.aux_num = 4'(num);
    end
    tick();
    bus.pkt_done = 1'b0;
    bus.aux_req  = 1'b0;
    if (req && req_at_done) m_pend = min31(m_pend + num - ((exp_t == 2) ? 1 : 0));
    else if (exp_t == 2) m_pend = m_pend - 1;
    if (exp_t == 2) m_aux++; else m_vid++;
    have_prev = 1;
    chk("rd_hits", hits, exp_len);
    chk("rd_first", first - m, 1);
    chk("rd_last", last - m, exp_len);
    chk("rd_wrong", wrong, 0);
    chk("vid_pkts", bus.vid_pkts, m_vid);
    chk("aux_pkts", bus.aux_pkts, m_aux);
    chk("aux_pend", dut.aux_pend_q, m_pend);
  endtask

  // Packet whose ack never comes.
  task automatic do_tmo();
    int exp_t, s, v0, a0;
    bit ok, seen;
    exp_t = predict();
    wait_start(ok);
    chk("tmo_start_seen", ok, 1);
    if (!ok) return;
    s = cyc;
    chk("tmo_pkt_type", bus.pkt_type, exp_t);
    grant(exp_t);
    v0 = vid_rd_cyc; a0 = aux_rd_cyc;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.err_tmo) begin seen = 1; break; end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_latency", cyc - s, TMO);
    tick();
    chk("tmo_pulse_1cyc", bus.err_tmo, 0);
    chk("tmo_type_clr", bus.pkt_type, 0);
    chk("tmo_no_rd", (vid_rd_cyc - v0) + (aux_rd_cyc - a0), 0);
    chk("tmo_vid_pkts", bus.vid_pkts, m_vid);
    chk("tmo_aux_pkts", bus.aux_pkts, m_aux);
    chk("tmo_aux_pend", dut.aux_pend_q, m_pend);
    have_prev = 0;
  endtask

  task automatic model_reset();
    m_pend = 0; m_run = 0; m_vid = 0; m_aux = 0; have_prev = 0;
  endtask

  initial begin
    bit ok;
    int m;
    logic [10:0] starve_exp;
    logic [2:0]  prio_exp;
    starve_exp = 11'b11110111101;
    prio_exp   = 3'b110;
    bus.vid_rdy = 1'b1; bus.aux_req = 1'b0; bus.aux_num = 4'd0;
    bus.aux_empty = 1'b0; bus.pkt_ack = 1'b0; bus.pkt_done = 1'b0;

    // reset state, including an aux_req ignored while in reset
    repeat (3) tick();
    bus.aux_req = 1'b1; bus.aux_num = 4'd7;
    tick();
    bus.aux_req = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_type", bus.pkt_type, 0);
    chk("rst_start", bus.pkt_start, 0);
    chk("rst_rd", {bus.vid_rd_en, bus.aux_rd_en}, 0);
    chk("rst_vid_pkts", bus.vid_pkts, 0);
    chk("rst_aux_pkts", bus.aux_pkts, 0);
    chk("rst_pend", dut.aux_pend_q, 0);
    rstbtn_n = 1'b1;

    // video only, then a second one carrying an aux_req of 2
    do_pkt(5, 27, 0, 0, 0);
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 1, 2, 0);

    // aux priority: A A V; the V carries aux_num = 9
    ord = 0;
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 0, 0, 0);
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 0, 0, 0);
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 1, 9, 0);
    chk("prio_order", ord[2:0], prio_exp);

    // starvation limit
    ord = 0;
    for (int k = 0; k < 11; k++)
      do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 0, 0, 0);
    chk("starve_order", ord[10:0], starve_exp);

    // saturation while idle, then overlap of aux_req with an aux pkt_done
    bus.vid_rdy = 1'b0; bus.aux_empty = 1'b1;
    repeat (20) tick();
    chk("idle_busy", bus.busy, 0);
    pulse_req(15);
    pulse_req(15);
    pulse_req(5);
    have_prev = 0;
    bus.aux_empty = 1'b0; bus.vid_rdy = 1'b1;
    do_pkt(3, 2, 1, 1, 1);

    // randomized traffic
    for (int k = 0; k < 20; k++) begin
      bus.vid_rdy   = ($urandom_range(0, 3) != 0);
      bus.aux_empty = ($urandom_range(0, 3) == 0);
      if (!bus.vid_rdy && !(m_pend > 0 && !bus.aux_empty)) bus.vid_rdy = 1'b1;
      do_pkt($urandom_range(1, 8), $urandom_range(0, 10), ($urandom_range(0, 2) == 0),
             $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // ack timeout, then arbitration resumes
    bus.vid_rdy = 1'b1;
    do_tmo();
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 0, 0, 0);

    // reset on the 4th read cycle of a video burst
    bus.aux_empty = 1'b1; bus.vid_rdy = 1'b1;
    wait_start(ok);
    chk("rb_start_seen", ok, 1);
    chk("rb_type", bus.pkt_type, 1);
    repeat (2) tick();
    bus.pkt_ack = 1'b1;
    m = cyc;
    tick();
    bus.pkt_ack = 1'b0;
    repeat (3) tick();
    chk("rb_4th_rd_cycle", cyc - m, 4);
    chk("rb_rd_before", bus.vid_rd_en, 1);
    #1 rstbtn_n = 1'b0;
    #1;
    chk("rb_rd_async", bus.vid_rd_en, 0);
    chk("rb_busy", bus.busy, 0);
    chk("rb_type_clr", bus.pkt_type, 0);
    chk("rb_pend", dut.aux_pend_q, 0);
    chk("rb_vid_pkts", bus.vid_pkts, 0);
    model_reset();
    tick();
    bus.aux_empty = 1'b0;
    rstbtn_n = 1'b1;
    do_pkt($urandom_range(1, 8), $urandom_range(0, 10), 0, 0, 0);

    chk("rd_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tx_pkt_sched.md
# tx_pkt_sched

Packet scheduler for the Ethernet transmit path, `tx_clk` domain, 125 MHz. It shares the GMII transmitter between the 48-bit video send FIFO and the 25-bit audio/aux send FIFO. It decides which packet goes next, sequences the FIFO read bursts against the transmitter's header/done handshake, and enforces the inter-frame gap. It sits between the two `afifo` instances and the `gmii_tx` framing engine.

## Interface
Parameters:
- VID_BURST, 10: video FIFO entries per video packet.
- AUX_LEN, 32: aux FIFO entries per aux packet (one ADE period).
- AUX_STREAK, 4: maximum consecutive aux packets while video is ready.
- IFG, 12: idle cycles after each packet.
- ACK_TMO, 255: maximum cycles to wait for `pkt_ack`.

Ports:
- tx_clk  in  1  — transmit clock; all logic is synchronous to its rising edge.
- rstbtn_n  in  1  — asynchronous, active-low reset.
- vid_rdy  in  1  — at least VID_BURST entries are present in the video FIFO (level).
- vid_rd_en  out  1  — video FIFO read enable.
- aux_req  in  1  — one-cycle pulse: ADE periods have been completed.
- aux_num  in  4  — number of completed periods; valid with `aux_req`.
- aux_empty  in  1  — aux FIFO empty.
- aux_rd_en  out  1  — aux FIFO read enable.
- pkt_start  out  1  — one-cycle pulse: the transmitter begins a packet.
- pkt_type  out  2  — 01 = video, 10 = aux, 00 = none; held from `pkt_start` to `pkt_done`.
- pkt_len  out  6  — entry count of the current packet; held with `pkt_type`.
- pkt_ack  in  1  — pulse from the transmitter: header sent, payload wanted.
- pkt_done  in  1  — pulse from the transmitter: last payload byte sent.
- busy  out  1  — high in every state except IDLE.
- err_tmo  out  1  — one-cycle pulse on an ack timeout.
- vid_pkts  out  16  — video packet counter; wraps.
- aux_pkts  out  16  — aux packet counter; wraps.

## Operation
States: IDLE, START, WAIT_ACK, BURST, WAIT_DONE, GAP.

Arbitration, evaluated in IDLE only:
- Aux is eligible when `aux_pend` > 0 and `aux_empty` = 0.
- Video is eligible when `vid_rdy` = 1.
- Aux wins, except when `streak` = AUX_STREAK and video is eligible; then video wins.
- A video grant clears `streak`.
- An aux grant increments `streak`, saturating at AUX_STREAK.
- With no eligible source, the block stays in IDLE.

Transitions:
- IDLE → START on any grant.
- START drives `pkt_start` = 1 and latches `pkt_type` and `pkt_len`, then goes to WAIT_ACK.
- WAIT_ACK → BURST on `pkt_ack`.
- WAIT_ACK → IDLE when the timeout counter reaches ACK_TMO. This pulses `err_tmo`, clears `pkt_type` to 00, reads no FIFO and leaves the counters unchanged.
- BURST asserts the selected rd_en for exactly `pkt_len` consecutive cycles, then goes to WAIT_DONE.
- WAIT_DONE → GAP on `pkt_done`. The matching packet counter increments on this edge. For aux, `aux_pend` decrements by 1.
- GAP counts IFG cycles, then goes to IDLE with `pkt_type` = 00.
- A `pkt_done` seen in any state other than WAIT_DONE is ignored.

`aux_pend` (5-bit):
- Adds `aux_num` on `aux_req` and saturates at 31.
- On a simultaneous add and decrement, the net value is applied (pend + num − 1, saturated).

Reset:
- Reset mid-packet returns the block to IDLE immediately.
- All outputs and counters clear to 0 and `pkt_type` to 00.
- `aux_pend` and `streak` clear.

## Timing
- Grant-to-start: IDLE at cycle n with an eligible source → START at n+1, so `pkt_start` is high during cycle n+1 → WAIT_ACK at n+2.
- Ack-to-read: `pkt_ack` at cycle m → rd_en is high for cycles m+1 through m+pkt_len. FIFO Q is valid one cycle after each rd_en.
- `vid_rd_en` and `aux_rd_en` are never high in the same cycle. Neither is high outside BURST.
- Timeout: the counter starts at 0 on entry to WAIT_ACK. `err_tmo` pulses in the cycle the counter equals ACK_TMO.
- Minimum packet spacing: `pkt_done` to the next `pkt_start` is IFG + 2 cycles.
- `aux_empty` going high during BURST does not truncate the burst. An eligible aux source guarantees AUX_LEN entries.

## Structure
- Package `tx_sched_pkg` holds:
  - the state enum;
  - the `pkt_type` codes TYPE_NONE, TYPE_VID and TYPE_AUX;
  - the parameter defaults.
- Sub-module `tx_sched_arb` holds the eligibility logic and priority/streak selection. It is combinational, and `streak` is the only register it owns.
- The FSM, burst counter, gap counter, timeout counter, `aux_pend` and the packet counters live in the top level.

## Test plan
- Video only: `vid_rdy` = 1, `aux_pend` = 0, ack 5 cycles after start, done 40 cycles after ack → `vid_rd_en` is high for 10 cycles starting 1 cycle after ack; `vid_pkts` = 1; next `pkt_start` comes 14 cycles after done.
- Aux priority: `aux_req` with `aux_num` = 2 while `vid_rdy` = 1 → two aux packets of 32 reads each are sent first; `aux_pend` goes 2 → 1 → 0; then video is sent.
- Starvation limit: `aux_num` = 9 with `vid_rdy` held at 1 → the packet order is A A A A V A A A A V A.
- Saturation and overlap: `aux_pend` = 30 with `aux_req` carrying `aux_num` = 5 → 31. Then `aux_req` with `aux_num` = 1 in the same cycle as an aux `pkt_done` → `aux_pend` stays 31.
- Timeout: no `pkt_ack` → `err_tmo` pulses 255 cycles after entry to WAIT_ACK; no rd_en is asserted; counters are unchanged; arbitration resumes.
- Reset mid-burst: `rstbtn_n` goes low on the 4th read cycle → `vid_rd_en` drops asynchronously; `busy`, `pkt_type` and `aux_pend` read 0/00 during reset.
